// File: rtl/wb_stage_pkg.sv
// Shared widths, load-size encodings and the captured load context for wb_stage.
package wb_stage_pkg;

    localparam int unsigned REG_W      = 32;
    localparam int unsigned REG_ADDR_W = 5;

    localparam logic [REG_W-1:0] ZERO_WORD = '0;

    // Load size encodings; 2'b11 is handled as a word
    localparam logic [1:0] LD_BYTE = 2'b00;
    localparam logic [1:0] LD_HALF = 2'b01;
    localparam logic [1:0] LD_WORD = 2'b10;

    // Everything about an accepted load that is needed when its response arrives
    typedef struct packed {
        logic                  rd_we;
        logic [REG_ADDR_W-1:0] rd_addr;
        logic [1:0]            size;
        logic                  ld_unsigned;
        logic [1:0]            addr_lo;
    } ld_ctx_t;

endpackage : wb_stage_pkg

// File: rtl/wb_stage_load_align.sv
// Load data alignment: picks the byte/half lane out of the raw bus word and extends it.
module wb_stage_load_align
    import wb_stage_pkg::*;
(
    input  logic [REG_W-1:0] raw_word,
    input  logic [1:0]       size,
    input  logic             ld_unsigned,
    input  logic [1:0]       addr_lo,
    output logic [REG_W-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select, then sign/zero extension by size
    always_comb begin
        byte_sel = raw_word[7:0];
        unique case (addr_lo)
            2'd0: byte_sel = raw_word[7:0];
            2'd1: byte_sel = raw_word[15:8];
            2'd2: byte_sel = raw_word[23:16];
            2'd3: byte_sel = raw_word[31:24];
            default: byte_sel = raw_word[7:0];
        endcase

        // addr_lo[0] is ignored for halves; misalignment never reaches this stage
        half_sel = addr_lo[1] ? raw_word[31:16] : raw_word[15:0];

        data = raw_word;
        unique case (size)
            LD_BYTE: data = ld_unsigned ? {{(REG_W-8){1'b0}}, byte_sel}
                                        : {{(REG_W-8){byte_sel[7]}}, byte_sel};
            LD_HALF: data = ld_unsigned ? {{(REG_W-16){1'b0}}, half_sel}
                                        : {{(REG_W-16){half_sel[15]}}, half_sel};
            default: data = raw_word;
        endcase
    end

endmodule : wb_stage_load_align

// File: rtl/wb_stage.sv
// Writeback stage: retires MEM-stage instructions, waits for load data, drives the RF write port.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TMO_W          = 8
) (
    input  logic                  clk_i,
    input  logic                  n_rst_i,

    input  logic                  mem_valid_i,
    output logic                  mem_ready_o,
    input  logic                  mem_rd_we_i,
    input  logic [REG_ADDR_W-1:0] mem_rd_addr_i,
    input  logic [REG_W-1:0]      mem_rd_wdata_i,
    input  logic                  mem_is_load_i,
    input  logic [1:0]            mem_ld_size_i,
    input  logic                  mem_ld_unsigned_i,
    input  logic [1:0]            mem_addr_lo_i,

    input  logic                  dmem_rsp_valid_i,
    input  logic [REG_W-1:0]      dmem_rsp_rdata_i,
    input  logic                  dmem_rsp_err_i,

    output logic                  rd_we_o,
    output logic [REG_ADDR_W-1:0] rd_addr_o,
    output logic [REG_W-1:0]      rd_wdata_o,
    output logic                  retire_o,
    output logic                  load_err_o,
    output logic                  busy_o
);

    typedef enum logic {
        S_IDLE      = 1'b0,
        S_WAIT_LOAD = 1'b1
    } state_e;

    state_e                state_q, state_d;
    ld_ctx_t               ctx_q, ctx_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;

    logic                  rd_we_d;
    logic [REG_ADDR_W-1:0] rd_addr_d;
    logic [REG_W-1:0]      rd_wdata_d;
    logic                  retire_d;
    logic                  load_err_d;

    logic [REG_W-1:0]      ld_data;
    logic                  tmo_hit;

    wb_stage_load_align u_load_align (
        .raw_word    (dmem_rsp_rdata_i),
        .size        (ctx_q.size),
        .ld_unsigned (ctx_q.ld_unsigned),
        .addr_lo     (ctx_q.addr_lo),
        .data        (ld_data)
    );

    // Handshake status follows the state directly
    assign mem_ready_o = (state_q == S_IDLE);
    assign busy_o      = (state_q == S_WAIT_LOAD);

    // Last waiting cycle before the load is declared lost
    assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    // Next state, load context, timeout count and next output values
    always_comb begin
        state_d    = state_q;
        ctx_d      = ctx_q;
        tmo_d      = tmo_q;
        rd_we_d    = 1'b0;
        rd_addr_d  = rd_addr_o;
        rd_wdata_d = rd_wdata_o;
        retire_d   = 1'b0;
        load_err_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (mem_valid_i) begin
                    if (mem_is_load_i) begin
                        ctx_d.rd_we       = mem_rd_we_i;
                        ctx_d.rd_addr     = mem_rd_addr_i;
                        ctx_d.size        = mem_ld_size_i;
                        ctx_d.ld_unsigned = mem_ld_unsigned_i;
                        ctx_d.addr_lo     = mem_addr_lo_i;
                        tmo_d             = '0;
                        state_d           = S_WAIT_LOAD;
                    end else begin
                        retire_d = 1'b1;
                        // x0 is hardwired, so it never sees a write
                        if (mem_rd_we_i && (mem_rd_addr_i != '0)) begin
                            rd_we_d    = 1'b1;
                            rd_addr_d  = mem_rd_addr_i;
                            rd_wdata_d = mem_rd_wdata_i;
                        end
                    end
                end
            end

            S_WAIT_LOAD: begin
                // A response on the timeout edge still wins
                if (dmem_rsp_valid_i) begin
                    state_d = S_IDLE;
                    if (dmem_rsp_err_i) begin
                        load_err_d = 1'b1;
                    end else begin
                        retire_d = 1'b1;
                        if (ctx_q.rd_we && (ctx_q.rd_addr != '0)) begin
                            rd_we_d    = 1'b1;
                            rd_addr_d  = ctx_q.rd_addr;
                            rd_wdata_d = ld_data;
                        end
                    end
                end else if (tmo_hit) begin
                    state_d    = S_IDLE;
                    load_err_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State, context and registered outputs
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            state_q    <= S_IDLE;
            ctx_q      <= '0;
            tmo_q      <= '0;
            rd_we_o    <= 1'b0;
            rd_addr_o  <= '0;
            rd_wdata_o <= ZERO_WORD;
            retire_o   <= 1'b0;
            load_err_o <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctx_q      <= ctx_d;
            tmo_q      <= tmo_d;
            rd_we_o    <= rd_we_d;
            rd_addr_o  <= rd_addr_d;
            rd_wdata_o <= rd_wdata_d;
            retire_o   <= retire_d;
            load_err_o <= load_err_d;
        end
    end

endmodule : wb_stage

// File: tb/tb_wb_stage.sv
// Directed + randomized-load bench for wb_stage with an expected-completion scoreboard.
module tb_wb_stage;
    import wb_stage_pkg::*;

    logic                  clk_i;
    logic                  n_rst_i;
    logic                  mem_valid_i;
    logic                  mem_ready_o;
    logic                  mem_rd_we_i;
    logic [REG_ADDR_W-1:0] mem_rd_addr_i;
    logic [REG_W-1:0]      mem_rd_wdata_i;
    logic                  mem_is_load_i;
    logic [1:0]            mem_ld_size_i;
    logic                  mem_ld_unsigned_i;
    logic [1:0]            mem_addr_lo_i;
    logic                  dmem_rsp_valid_i;
    logic [REG_W-1:0]      dmem_rsp_rdata_i;
    logic                  dmem_rsp_err_i;
    logic                  rd_we_o;
    logic [REG_ADDR_W-1:0] rd_addr_o;
    logic [REG_W-1:0]      rd_wdata_o;
    logic                  retire_o;
    logic                  load_err_o;
    logic                  busy_o;

    typedef struct {
        logic                  we;
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_W-1:0]      data;
        logic                  retire;
        logic                  err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    wb_stage #(.TIMEOUT_CYCLES(4), .TMO_W(3)) dut (
        .clk_i             (clk_i),
        .n_rst_i           (n_rst_i),
        .mem_valid_i       (mem_valid_i),
        .mem_ready_o       (mem_ready_o),
        .mem_rd_we_i       (mem_rd_we_i),
        .mem_rd_addr_i     (mem_rd_addr_i),
        .mem_rd_wdata_i    (mem_rd_wdata_i),
        .mem_is_load_i     (mem_is_load_i),
        .mem_ld_size_i     (mem_ld_size_i),
        .mem_ld_unsigned_i (mem_ld_unsigned_i),
        .mem_addr_lo_i     (mem_addr_lo_i),
        .dmem_rsp_valid_i  (dmem_rsp_valid_i),
        .dmem_rsp_rdata_i  (dmem_rsp_rdata_i),
        .dmem_rsp_err_i    (dmem_rsp_err_i),
        .rd_we_o           (rd_we_o),
        .rd_addr_o         (rd_addr_o),
        .rd_wdata_o        (rd_wdata_o),
        .retire_o          (retire_o),
        .load_err_o        (load_err_o),
        .busy_o            (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference load extraction, written as shift-and-mask
    function automatic logic [31:0] model_load(input logic [31:0] raw, input logic [1:0] size,
                                               input logic uns, input logic [1:0] lo);
        logic [31:0] v;
        if (size == 2'b00) begin
            v = (raw >> (8 * int'(lo))) & 32'h0000_00FF;
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        end else if (size == 2'b01) begin
            v = (raw >> (lo[1] ? 16 : 0)) & 32'h0000_FFFF;
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = raw;
        end
        return v;
    endfunction

    // Scoreboard: every completion event must match the oldest expectation
    always @(negedge clk_i) begin
        if (n_rst_i && (rd_we_o || retire_o || load_err_o)) begin
            if (exp_q.size() == 0) begin
                chk("spurious_event", {29'd0, rd_we_o, retire_o, load_err_o}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_rd_we", 32'(rd_we_o), 32'(e.we));
                chk("sb_retire", 32'(retire_o), 32'(e.retire));
                chk("sb_load_err", 32'(load_err_o), 32'(e.err));
                if (e.we) begin
                    chk("sb_rd_addr", 32'(rd_addr_o), 32'(e.addr));
                    chk("sb_rd_wdata", rd_wdata_o, e.data);
                end
            end
        end
    end

    function automatic exp_t mk(input logic we, input logic [4:0] a, input logic [31:0] d,
                                input logic ret, input logic err);
        exp_t e;
        e.we = we; e.addr = a; e.data = d; e.retire = ret; e.err = err;
        return e;
    endfunction

    // Present a non-load for one edge; valid is left high for back-to-back use
    task automatic send_nl(input logic [4:0] a, input logic [31:0] d, input logic we);
        chk("nl_ready", 32'(mem_ready_o), 32'd1);
        mem_valid_i = 1'b1; mem_is_load_i = 1'b0;
        mem_rd_we_i = we; mem_rd_addr_i = a; mem_rd_wdata_i = d;
        exp_q.push_back(mk(we && (a != 0), a, d, 1'b1, 1'b0));
        @(posedge clk_i); #1;
        chk("nl_retire", 32'(retire_o), 32'd1);
    endtask

    task automatic idle();
        mem_valid_i = 1'b0;
    endtask

    task automatic send_ld(input logic [4:0] a, input logic we, input logic [1:0] sz,
                           input logic uns, input logic [1:0] lo);
        chk("ld_ready", 32'(mem_ready_o), 32'd1);
        mem_valid_i = 1'b1; mem_is_load_i = 1'b1;
        mem_rd_we_i = we; mem_rd_addr_i = a; mem_rd_wdata_i = 32'hBAD0_BAD0;
        mem_ld_size_i = sz; mem_ld_unsigned_i = uns; mem_addr_lo_i = lo;
        @(posedge clk_i); #1;
        mem_valid_i = 1'b0;
        mem_addr_lo_i = ~lo; mem_ld_size_i = ~sz; mem_ld_unsigned_i = ~uns;
        chk("ld_busy", 32'(busy_o), 32'd1);
        chk("ld_no_retire", 32'(retire_o), 32'd0);
    endtask

    // Respond d edges after the accept edge
    task automatic respond(input int d, input logic [31:0] raw, input logic err, input exp_t e);
        exp_q.push_back(e);
        repeat (d - 1) begin
            @(posedge clk_i); #1;
            chk("wait_busy", 32'(busy_o), 32'd1);
        end
        dmem_rsp_valid_i = 1'b1; dmem_rsp_rdata_i = raw; dmem_rsp_err_i = err;
        @(posedge clk_i); #1;
        dmem_rsp_valid_i = 1'b0; dmem_rsp_err_i = 1'b0;
        chk("rsp_ready", 32'(mem_ready_o), 32'd1);
        chk("rsp_busy", 32'(busy_o), 32'd0);
    endtask

    initial begin
        n_rst_i = 1'b0;
        mem_valid_i = 1'b0; mem_rd_we_i = 1'b0; mem_rd_addr_i = '0; mem_rd_wdata_i = '0;
        mem_is_load_i = 1'b0; mem_ld_size_i = 2'b00; mem_ld_unsigned_i = 1'b0; mem_addr_lo_i = 2'b00;
        dmem_rsp_valid_i = 1'b0; dmem_rsp_rdata_i = '0; dmem_rsp_err_i = 1'b0;

        #12;
        chk("rst_rd_we", 32'(rd_we_o), 32'd0);
        chk("rst_retire", 32'(retire_o), 32'd0);
        chk("rst_load_err", 32'(load_err_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_ready", 32'(mem_ready_o), 32'd1);
        chk("rst_rd_addr", 32'(rd_addr_o), 32'd0);
        chk("rst_rd_wdata", rd_wdata_o, 32'd0);
        @(negedge clk_i); n_rst_i = 1'b1;
        @(posedge clk_i); #1;

        // Single non-load, then pulses drop and data holds
        send_nl(5'd5, 32'h1234_5678, 1'b1);
        chk("nl_rd_we", 32'(rd_we_o), 32'd1);
        chk("nl_rd_addr", 32'(rd_addr_o), 32'd5);
        chk("nl_rd_wdata", rd_wdata_o, 32'h1234_5678);
        idle();
        @(posedge clk_i); #1;
        chk("n2_rd_we", 32'(rd_we_o), 32'd0);
        chk("n2_retire", 32'(retire_o), 32'd0);
        chk("n2_hold_wdata", rd_wdata_o, 32'h1234_5678);

        // Write to x0 retires without a write
        send_nl(5'd0, 32'hDEAD_BEEF, 1'b1);
        chk("x0_rd_we", 32'(rd_we_o), 32'd0);
        idle();
        @(posedge clk_i); #1;

        // Three back-to-back non-loads
        send_nl(5'd1, 32'h0000_0011, 1'b1);
        send_nl(5'd2, 32'h0000_0022, 1'b1);
        send_nl(5'd3, 32'h0000_0033, 1'b1);
        idle();
        @(posedge clk_i); #1;

        // Byte loads from lane 3, signed and unsigned
        send_ld(5'd7, 1'b1, LD_BYTE, 1'b0, 2'd3);
        respond(2, 32'h80FF_0011, 1'b0, mk(1'b1, 5'd7, 32'hFFFF_FF80, 1'b1, 1'b0));
        send_ld(5'd7, 1'b1, LD_BYTE, 1'b1, 2'd3);
        respond(2, 32'h80FF_0011, 1'b0, mk(1'b1, 5'd7, 32'h0000_0080, 1'b1, 1'b0));

        // Half loads from the upper half
        send_ld(5'd8, 1'b1, LD_HALF, 1'b0, 2'd2);
        respond(1, 32'h8001_7FFF, 1'b0, mk(1'b1, 5'd8, 32'hFFFF_8001, 1'b1, 1'b0));
        send_ld(5'd8, 1'b1, LD_HALF, 1'b1, 2'd2);
        respond(3, 32'h8001_7FFF, 1'b0, mk(1'b1, 5'd8, 32'h0000_8001, 1'b1, 1'b0));

        // Word loads (10 and 11) ignore addr_lo and unsigned
        send_ld(5'd9, 1'b1, LD_WORD, 1'b1, 2'd1);
        respond(2, 32'hCAFE_F00D, 1'b0, mk(1'b1, 5'd9, 32'hCAFE_F00D, 1'b1, 1'b0));
        send_ld(5'd10, 1'b1, 2'b11, 1'b0, 2'd2);
        respond(1, 32'h8765_4321, 1'b0, mk(1'b1, 5'd10, 32'h8765_4321, 1'b1, 1'b0));

        // Bus error, then an accept on the very next edge
        send_ld(5'd11, 1'b1, LD_WORD, 1'b0, 2'd0);
        respond(2, 32'h5555_5555, 1'b1, mk(1'b0, 5'd0, 32'd0, 1'b0, 1'b1));
        send_nl(5'd12, 32'h0BAD_F00D, 1'b1);
        idle();
        @(posedge clk_i); #1;

        // Timeout: error registered on the 4th edge after accept
        send_ld(5'd13, 1'b1, LD_WORD, 1'b0, 2'd0);
        exp_q.push_back(mk(1'b0, 5'd0, 32'd0, 1'b0, 1'b1));
        repeat (3) begin
            @(posedge clk_i); #1;
            chk("tmo_busy", 32'(busy_o), 32'd1);
            chk("tmo_no_err", 32'(load_err_o), 32'd0);
        end
        @(posedge clk_i); #1;
        chk("tmo_load_err", 32'(load_err_o), 32'd1);
        chk("tmo_ready", 32'(mem_ready_o), 32'd1);
        @(posedge clk_i); #1;
        chk("tmo_err_pulse", 32'(load_err_o), 32'd0);

        // Response on the timeout edge wins
        send_ld(5'd14, 1'b1, LD_HALF, 1'b0, 2'd0);
        respond(4, 32'h1234_F0F0, 1'b0, mk(1'b1, 5'd14, 32'hFFFF_F0F0, 1'b1, 1'b0));

        // Randomized loads against the reference extraction
        for (int i = 0; i < 8; i++) begin
            logic [4:0]  a;
            logic [1:0]  sz, lo;
            logic        uns;
            logic [31:0] raw;
            a = 5'($urandom_range(1, 31)); sz = 2'($urandom_range(0, 3));
            lo = 2'($urandom_range(0, 3)); uns = 1'($urandom_range(0, 1));
            raw = $urandom();
            if (sz == LD_HALF) lo[0] = 1'b0;
            send_ld(a, 1'b1, sz, uns, lo);
            respond($urandom_range(1, 3), raw, 1'b0, mk(1'b1, a, model_load(raw, sz, uns, lo), 1'b1, 1'b0));
        end

        // Reset in the middle of a load; a late response must be ignored
        send_ld(5'd15, 1'b1, LD_WORD, 1'b0, 2'd0);
        #2 n_rst_i = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy_o), 32'd0);
        chk("mid_rst_ready", 32'(mem_ready_o), 32'd1);
        chk("mid_rst_wdata", rd_wdata_o, 32'd0);
        @(negedge clk_i); n_rst_i = 1'b1;
        @(posedge clk_i); #1;
        dmem_rsp_valid_i = 1'b1; dmem_rsp_rdata_i = 32'hFEED_FACE;
        @(posedge clk_i); #1;
        dmem_rsp_valid_i = 1'b0;
        repeat (3) begin
            chk("late_rsp_rd_we", 32'(rd_we_o), 32'd0);
            chk("late_rsp_retire", 32'(retire_o), 32'd0);
            @(posedge clk_i); #1;
        end

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_wb_stage

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the in-order core, between the MEM stage and the general-purpose register file write port.
- Accepts one retiring instruction per handshake and waits for the data-memory response on loads.
- Aligns and sign/zero-extends load data, then drives a one-cycle registered write (we/addr/data) into the register file.
- Reports busy, retire and load-error status to the hazard/trap logic.

Parameters:
- TIMEOUT_CYCLES, 255: cycles spent waiting for a load response before an error is declared. 0 disables the timeout.
- TMO_W, 8: width of the timeout counter. Must satisfy 2^TMO_W > TIMEOUT_CYCLES.

Ports:
- clk_i  in  1  core clock
- n_rst_i  in  1  asynchronous active-low reset
- mem_valid_i  in  1  MEM stage presents an instruction
- mem_ready_o  out  1  wb_stage accepts the instruction
- mem_rd_we_i  in  1  instruction writes rd
- mem_rd_addr_i  in  `RegAddrBus  destination register
- mem_rd_wdata_i  in  `RegBus  ALU/CSR result (non-load)
- mem_is_load_i  in  1  instruction is a load
- mem_ld_size_i  in  2  00 byte, 01 half, 10 word, 11 treated as word
- mem_ld_unsigned_i  in  1  zero-extend instead of sign-extend
- mem_addr_lo_i  in  2  load address bits [1:0]
- dmem_rsp_valid_i  in  1  data bus read response valid
- dmem_rsp_rdata_i  in  `RegBus  raw aligned 32-bit word
- dmem_rsp_err_i  in  1  bus error on response
- rd_we_o  out  1  register file write enable
- rd_addr_o  out  `RegAddrBus  register file write address
- rd_wdata_o  out  `RegBus  register file write data
- retire_o  out  1  one-cycle pulse per completed instruction
- load_err_o  out  1  one-cycle pulse: load bus error or timeout
- busy_o  out  1  high while waiting for a load response

Behaviour:
- Clock and reset: one clock, clk_i. n_rst_i is asynchronous, active-low.
- Reset values: state IDLE; rd_we_o, retire_o, load_err_o and busy_o all 0; rd_addr_o = 0; rd_wdata_o = `ZeroWord; timeout counter 0.
- States: IDLE and WAIT_LOAD.
- mem_ready_o: equal to (state == IDLE); combinational. busy_o is its inverse.
- IDLE, accept of a non-load (valid & ready, is_load = 0), edge N:
  - In cycle N+1: rd_we_o = mem_rd_we_i & (mem_rd_addr_i != 0), rd_addr_o/rd_wdata_o = captured values, retire_o = 1.
  - Remain in IDLE, so back-to-back non-loads retire one per cycle.
- IDLE, accept of a load:
  - Capture rd_we, rd_addr, size, unsigned and addr_lo. Go to WAIT_LOAD and clear the timeout counter.
  - No write and no retire in the following cycle.
- WAIT_LOAD, on dmem_rsp_valid_i at edge M:
  - err = 0: in cycle M+1, rd_we_o = captured we & (addr != 0); rd_wdata_o = extracted data; retire_o = 1.
  - err = 1: in cycle M+1, rd_we_o = 0, load_err_o = 1, retire_o = 0.
  - Either way, return to IDLE. mem_ready_o rises in cycle M+1, so a new accept can occur at edge M+1.
- WAIT_LOAD without a response: the counter increments each cycle.
  - When TIMEOUT_CYCLES != 0 and the counter == TIMEOUT_CYCLES - 1 with no response, treat it as err = 1 (same outputs as above) and return to IDLE.
  - A response arriving on that same edge takes priority over the timeout.
- Extraction rules:
  - Byte: take byte lane mem_addr_lo_i[1:0] (lane 0 = bits 7:0).
  - Half: take bits 15:0 if addr_lo[1] = 0, else bits 31:16; addr_lo[0] is ignored (misalignment is trapped upstream).
  - Word: take the full word; addr_lo is ignored.
  - Sign-extend from bit 7 or bit 15 unless unsigned is set, in which case zero-extend. Word loads ignore the unsigned flag.
- dmem_rsp_valid_i while in IDLE: ignored, with no state change.
- rd_we_o, retire_o and load_err_o are single-cycle pulses, deasserted in every cycle without a completion event.
- rd_addr_o and rd_wdata_o hold their last values when rd_we_o = 0.
- Reset asserted mid-load: immediately return to IDLE with all outputs at reset values. A late response after reset release is ignored.

Decomposition:
- Shared defines (existing defines.v):
  - load size encodings `LdByte = 2'b00, `LdHalf = 2'b01, `LdWord = 2'b10;
  - reuse `RegBus, `RegAddrBus, `ZeroWord, `RstEnable, `WriteEnable.
- State encoding stays local to the module.
- Sub-module load_align: purely combinational (raw word, size, unsigned, addr_lo) -> 32-bit extended data. It is instantiated once and unit-tested separately.

Test Plan:
- Non-load x5, wdata 0x1234_5678, accepted at edge N -> cycle N+1: rd_we_o = 1, rd_addr_o = 5, rd_wdata_o = 0x12345678, retire_o = 1; in cycle N+2 both rd_we_o and retire_o = 0.
- Non-load to x0 -> rd_we_o = 0 and retire_o = 1. Three back-to-back non-loads -> three consecutive retire pulses with mem_ready_o held at 1.
- Signed byte load, addr_lo = 3, response 0x80FF_0011 two cycles after accept -> busy_o = 1 for 2 cycles, then rd_wdata_o = 0xFFFF_FF80.
- Same transaction with unsigned set -> rd_wdata_o = 0x0000_0080.
- Half load, addr_lo = 2, response 0x8001_7FFF -> signed 0xFFFF_8001, unsigned 0x0000_8001. Word load -> data unchanged.
- Load with dmem_rsp_err_i = 1 -> load_err_o pulse, rd_we_o = 0, retire_o = 0.
- TIMEOUT_CYCLES = 4 with no response -> load_err_o pulses 4 cycles after accept and mem_ready_o returns to 1.
- n_rst_i low during WAIT_LOAD -> busy_o = 0 immediately and a later dmem_rsp_valid_i produces no write.
